// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM states and width constants for the serial datapath.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor with start/busy/done handshake.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = arith_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             v;

    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out, v
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out, v
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - b_in, one bit per clock, LSB first.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);

    localparam int unsigned KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]    r_q;
    logic             br_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             v_q;
    logic             busy_q;
    logic             done_q;

    logic             x_c;
    logic             br_next_c;
    logic [WIDTH-1:0] res_c;

    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .diff (x_c),
        .bout (br_next_c)
    );

    // R keeps the first WIDTH-1 bits; the final bit joins it only when the result is registered.
    assign res_c = {x_c, r_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            k_q     <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        br_q    <= bus.b_in;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q  <= a_q >> 1;
                    b_q  <= b_q >> 1;
                    r_q  <= RW'(res_c >> 1);
                    br_q <= br_next_c;
                    k_q  <= k_q + KW'(1);
                    // br_q here is the borrow into the MSB; overflow is its mismatch with the borrow out.
                    if (k_q == K_LAST) begin
                        d_q     <= res_c;
                        bout_q  <= br_next_c;
                        v_q     <= br_q ^ br_next_c;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.d     = d_q;
    assign bus.b_out = bout_q;
    assign bus.v     = v_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple subtractor. Computes d = a - b - b_in over WIDTH cycles, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the inverse-operation counterpart of the team's ripple carry adder, and reuses the same operand/flag conventions.
- Sits in the arithmetic datapath as an area-cheap alternative to a parallel subtractor.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (must be ≥ 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while idle
- a  input  WIDTH  minuend, unsigned or two's complement
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow in
- busy  output  1  high while an operation is in progress (RUN or DONE)
- done  output  1  one-cycle pulse; results valid
- d  output  WIDTH  difference, modulo 2^WIDTH
- b_out  output  1  borrow out; 1 when a < b + b_in (unsigned)
- v  output  1  signed overflow flag

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset, on any clk edge with rst=1, from any state including mid-operation:
  - state returns to IDLE.
  - busy=0, done=0, d=0, b_out=0, v=0.
  - Internal shift registers, bit counter and borrow register are cleared.
  - An operation in progress is abandoned and no done is produced.
  - rst takes priority over start.
- States:
  - IDLE: busy=0. On an edge with start=1, latch a into shift register A, b into shift register B, and b_in into the borrow register br. Clear bit counter k to 0 and go to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each edge computes one full-subtractor step:
    - x = A[0] ^ B[0] ^ br
    - br' = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br)
    - x shifts into the MSB of the result shift register R; A and B shift right; k increments.
    - On the edge where k == WIDTH-1, after the final bit, go to DONE.
    - Before the final bit is processed, capture the borrow into the MSB (br at bit WIDTH-1) for the overflow calculation.
  - DONE: busy=1, done=1 for exactly one cycle. The next edge goes to IDLE unconditionally.
- Output updates:
  - d, b_out and v are registered.
  - They update on the RUN→DONE edge: d=R, b_out=final br, v = (borrow into MSB) XOR (borrow out of MSB).
  - They hold until the next RUN→DONE edge or reset. Starting a new operation does not clear them.
- Latency:
  - Start-accept edge at cycle 0. done is high during cycle WIDTH+1, so WIDTH=8 gives done in cycle 9.
  - Back-to-back: the earliest next accept is the edge ending the IDLE cycle after DONE. Throughput is one result per WIDTH+2 cycles.
- start asserted in RUN or DONE is ignored and not queued. a, b and b_in may change freely after the accept edge.
- Arithmetic rules:
  - d always equals (a - b - b_in) mod 2^WIDTH.
  - b_out equals the unsigned borrow.
  - v equals 1 exactly when the signed interpretation of a - b - b_in does not fit in WIDTH bits.
- Boundary cases:
  - a = b with b_in=0 → d=0, b_out=0.
  - a=0, b=0, b_in=1 → d all ones, b_out=1.
  - b all ones with b_in=1 → borrow propagates through every bit; the result must still be correct.

Decomposition:
- Shared package (arith_pkg), containing:
  - state enumeration {IDLE, RUN, DONE}
  - default WIDTH constant
  - counter width constant $clog2(WIDTH)
- Sub-module full_subtractor: combinational, ports x, y, bin → diff, bout.
  - Instantiated once inside serial_subtractor.
  - Can be exhaustively checked on its own (8 input cases).

Test Plan:
1. Reset, then start with a=3, b=2, b_in=0 → done pulse in cycle 9 after accept; d=1, b_out=0, v=0. busy is high for exactly 9 cycles.
2. a=0, b=7, b_in=1 → d=248, b_out=1, v=0.
3. a=128, b=1, b_in=0 → d=127, b_out=0, v=1. Then a=12, b=3, b_in=0 → d=9, v=0.
4. a=0, b=255, b_in=1 → d=0, b_out=1, v=0 (full borrow ripple). Then a=5, b=5, b_in=0 → d=0, b_out=0.
5. Start a=14, b=1; pulse start again with a=1, b=9 in cycle 3 → second request ignored; d=13 only, single done pulse. Then start a=1, b=9, b_in=1 after return to IDLE → d=247, b_out=1.
6. Start a=200, b=100; assert rst in cycle 4 → next cycle busy=0, done=0, d=0, b_out=0, v=0, and no done pulse ever appears. A following start with a=9, b=4 yields d=5.
